// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD add/sub datapath.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] BCD_ADJ       = 4'd6;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder with decimal correction; used for both the main pass
// and the re-complement pass.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (raw > {1'b0, BCD_MAX_DIGIT}) begin
      sum  = raw[3:0] + BCD_ADJ;
      cout = 1'b1;
    end else begin
      sum  = raw[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_ndigit_serial_add_sub.sv
// Digit-serial BCD adder/subtractor: one digit per clock, LSD first, with
// optional sign-magnitude re-complement of negative differences.
module bcd_ndigit_serial_add_sub
  import bcd_pkg::*;
#(
  parameter int DIGITS  = 3,
  parameter int MAG_OUT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] BCD_X,
  input  logic [4*DIGITS-1:0] BCD_Y,
  input  logic                mode,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] BCD_R,
  output logic                kout,
  output logic                neg,
  output logic                err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t           state;
  logic [W-1:0]     x_sh;
  logic [W-1:0]     y_sh;
  logic             mode_q;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic             bad_digit;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic [3:0]       add_sum;
  logic             add_cout;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (BCD_X[4*i +: 4] > BCD_MAX_DIGIT || BCD_Y[4*i +: 4] > BCD_MAX_DIGIT)
        bad_digit = 1'b1;
    end
  end

  // FIX reuses the same digit adder: (9 - r_i) + carry ripples the +1.
  always_comb begin
    add_a = x_sh[3:0];
    add_b = (mode_q == MODE_SUB) ? (BCD_MAX_DIGIT - y_sh[3:0]) : y_sh[3:0];
    if (state == FIX) begin
      add_a = BCD_MAX_DIGIT - BCD_R[3:0];
      add_b = 4'd0;
    end
  end

  bcd_digit_add u_digit (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      x_sh   <= '0;
      y_sh   <= '0;
      mode_q <= MODE_ADD;
      carry  <= 1'b0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      BCD_R  <= '0;
      kout   <= 1'b0;
      neg    <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_sh   <= BCD_X;
            y_sh   <= BCD_Y;
            mode_q <= mode;
            idx    <= '0;
            carry  <= (mode == MODE_SUB);
            neg    <= 1'b0;
            kout   <= 1'b0;
            BCD_R  <= '0;
            err    <= bad_digit;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          // An invalid operand spends this cycle idle so error latency is two cycles.
          if (err) begin
            state <= DONE;
          end else begin
            x_sh  <= x_sh >> 4;
            y_sh  <= y_sh >> 4;
            BCD_R <= (BCD_R >> 4) | (W'(add_sum) << (W - 4));
            carry <= add_cout;
            if (idx == LAST_IDX) begin
              idx  <= '0;
              kout <= add_cout;
              if (mode_q == MODE_SUB && !add_cout && MAG_OUT != 0) begin
                carry <= 1'b1;
                state <= FIX;
              end else begin
                state <= DONE;
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        FIX: begin
          BCD_R <= (BCD_R >> 4) | (W'(add_sum) << (W - 4));
          carry <= add_cout;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            neg   <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_ndigit_serial_add_sub.sv
// Scoreboard bench: three DUT configurations checked against an integer
// arithmetic reference model.
module tb_bcd_ndigit_serial_add_sub;

  typedef struct {
    logic [23:0] r;
    logic        k;
    logic        n;
    logic        e;
    int          lat;
    int          t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start3, start6, mode3, mode6;
  logic [11:0] x3, y3;
  logic [23:0] x6, y6;

  logic        busy_a, done_a, kout_a, neg_a, err_a;
  logic        busy_b, done_b, kout_b, neg_b, err_b;
  logic        busy_c, done_c, kout_c, neg_c, err_c;
  logic [11:0] r_a, r_b;
  logic [23:0] r_c;

  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  bcd_ndigit_serial_add_sub #(.DIGITS(3), .MAG_OUT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start3), .BCD_X(x3), .BCD_Y(y3), .mode(mode3),
    .busy(busy_a), .done(done_a), .BCD_R(r_a), .kout(kout_a), .neg(neg_a), .err(err_a));

  bcd_ndigit_serial_add_sub #(.DIGITS(3), .MAG_OUT(0)) dut_b (
    .clk(clk), .rst(rst), .start(start3), .BCD_X(x3), .BCD_Y(y3), .mode(mode3),
    .busy(busy_b), .done(done_b), .BCD_R(r_b), .kout(kout_b), .neg(neg_b), .err(err_b));

  bcd_ndigit_serial_add_sub #(.DIGITS(6), .MAG_OUT(1)) dut_c (
    .clk(clk), .rst(rst), .start(start6), .BCD_X(x6), .BCD_Y(y6), .mode(mode6),
    .busy(busy_c), .done(done_c), .BCD_R(r_c), .kout(kout_c), .neg(neg_c), .err(err_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint pow10(int d);
    longint p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic longint bcd2int(logic [23:0] v, int d);
    longint acc = 0;
    for (int i = d - 1; i >= 0; i--) acc = acc * 10 + longint'(v[4*i +: 4]);
    return acc;
  endfunction

  function automatic logic [23:0] int2bcd(longint v, int d);
    logic [23:0] r = '0;
    longint t = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference: plain decimal arithmetic on the operand values.
  function automatic exp_t model(logic [23:0] x, logic [23:0] y, logic m, int d, bit mag, int t0);
    exp_t e;
    bit bad = 0;
    longint xv, yv, p;
    for (int i = 0; i < d; i++)
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1;
    e.t0 = t0; e.r = '0; e.k = 0; e.n = 0; e.e = 0; e.lat = d + 1;
    if (bad) begin
      e.e = 1; e.lat = 2;
      return e;
    end
    xv = bcd2int(x, d);
    yv = bcd2int(y, d);
    p  = pow10(d);
    if (!m) begin
      e.r = int2bcd((xv + yv) % p, d);
      e.k = (xv + yv) >= p;
    end else if (xv >= yv) begin
      e.r = int2bcd(xv - yv, d);
      e.k = 1;
    end else if (mag) begin
      e.r = int2bcd(yv - xv, d);
      e.n = 1;
      e.lat = 2 * d + 1;
    end else begin
      e.r = int2bcd(p + xv - yv, d);
    end
    return e;
  endfunction

  function automatic logic [23:0] rand_bcd(int d, bit allow_bad);
    logic [23:0] v = '0;
    for (int i = 0; i < d; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && $urandom_range(0, 7) == 0)
      v[4*$urandom_range(0, d - 1) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      if (qa.size() == 0) checkOutput("a_unexpected_done", 1, 0);
      else begin
        ea = qa.pop_front();
        checkOutput("a_R", r_a, ea.r[11:0]);
        checkOutput("a_kout", kout_a, ea.k);
        checkOutput("a_neg", neg_a, ea.n);
        checkOutput("a_err", err_a, ea.e);
        checkOutput("a_busy_in_done", busy_a, 0);
        checkOutput("a_latency", 64'(cyc - ea.t0), 64'(ea.lat));
      end
    end
    if (done_b === 1'b1) begin
      if (qb.size() == 0) checkOutput("b_unexpected_done", 1, 0);
      else begin
        eb = qb.pop_front();
        checkOutput("b_R", r_b, eb.r[11:0]);
        checkOutput("b_kout", kout_b, eb.k);
        checkOutput("b_neg", neg_b, eb.n);
        checkOutput("b_err", err_b, eb.e);
        checkOutput("b_latency", 64'(cyc - eb.t0), 64'(eb.lat));
      end
    end
    if (done_c === 1'b1) begin
      if (qc.size() == 0) checkOutput("c_unexpected_done", 1, 0);
      else begin
        ec = qc.pop_front();
        checkOutput("c_R", r_c, ec.r);
        checkOutput("c_kout", kout_c, ec.k);
        checkOutput("c_neg", neg_c, ec.n);
        checkOutput("c_err", err_c, ec.e);
        checkOutput("c_latency", 64'(cyc - ec.t0), 64'(ec.lat));
      end
    end
  end

  // Issues one start as soon as the chosen DUT is idle (the done cycle counts).
  task automatic applyStimulus(int sel, logic [23:0] x, logic [23:0] y, logic m, bit push);
    int n = 0;
    @(negedge clk);
    while (((sel == 0) ? busy_a : busy_c) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("idle_timeout", 1, 0);
    if (sel == 0) begin
      x3 = x[11:0]; y3 = y[11:0]; mode3 = m; start3 = 1'b1;
    end else begin
      x6 = x; y6 = y; mode6 = m; start6 = 1'b1;
    end
    @(posedge clk);
    #1;
    if (sel == 0) begin
      if (push) begin
        qa.push_back(model(x, y, m, 3, 1, cyc));
        qb.push_back(model(x, y, m, 3, 0, cyc));
      end
      checkOutput("a_busy_after_start", busy_a, 1);
    end else begin
      if (push) qc.push_back(model(x, y, m, 6, 1, cyc));
      checkOutput("c_busy_after_start", busy_c, 1);
    end
    @(negedge clk);
    start3 = 1'b0;
    start6 = 1'b0;
    x3 = 12'($urandom); y3 = 12'($urandom); mode3 = 1'($urandom);
    x6 = 24'($urandom); y6 = 24'($urandom); mode6 = 1'($urandom);
  endtask

  initial begin
    int n;
    rst = 1'b1; start3 = 0; start6 = 0; mode3 = 0; mode6 = 0;
    x3 = '0; y3 = '0; x6 = '0; y6 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_a_outputs", {busy_a, done_a, r_a, kout_a, neg_a, err_a}, 0);
    checkOutput("reset_c_outputs", {busy_c, done_c, r_c, kout_c, neg_c, err_c}, 0);
    rst = 1'b0;

    applyStimulus(0, 24'h999, 24'h999, 0, 1);
    applyStimulus(0, 24'h548, 24'h459, 0, 1);
    // Re-pulse start while busy: must be ignored.
    @(negedge clk);
    start3 = 1'b1; x3 = 12'h111; y3 = 12'h222; mode3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    applyStimulus(0, 24'h108, 24'h051, 1, 1);
    applyStimulus(0, 24'h569, 24'h568, 1, 1);
    applyStimulus(0, 24'h999, 24'h999, 1, 1);
    applyStimulus(0, 24'h387, 24'h616, 1, 1);
    applyStimulus(0, 24'h765, 24'h943, 1, 1);
    applyStimulus(0, 24'h1A3, 24'h001, 0, 1);
    applyStimulus(0, 24'h000, 24'h000, 1, 1);

    for (int i = 0; i < 40; i++)
      applyStimulus(0, rand_bcd(3, 1), rand_bcd(3, 1), 1'($urandom), 1);

    // Reset during the second CALC cycle: result discarded, no done.
    applyStimulus(0, 24'h456, 24'h789, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_a_outputs", {busy_a, done_a, r_a, kout_a, neg_a, err_a}, 0);
    checkOutput("midreset_b_outputs", {busy_b, done_b, r_b, kout_b, neg_b, err_b}, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    applyStimulus(1, 24'h999999, 24'h000001, 0, 1);
    applyStimulus(1, 24'h123456, 24'h654321, 1, 1);
    for (int i = 0; i < 12; i++)
      applyStimulus(1, rand_bcd(6, 1), rand_bcd(6, 1), 1'($urandom), 1);

    n = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pending_results", 64'(qa.size() + qb.size() + qc.size()), 0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
